// File: rtl/cma_pkg.sv
// Shared types and operand-lane layout for complex_mult_arbiter.
package cma_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } cma_state_e;

    // Component slots inside one requester lane, in units of DW
    localparam int OP1_RE_SLOT = 0;
    localparam int OP1_IM_SLOT = 1;
    localparam int OP2_RE_SLOT = 2;
    localparam int OP2_IM_SLOT = 3;
    localparam int LANE_SLOTS  = 4;

endpackage

// File: rtl/cma_rr_arb.sv
// Combinational winner pick for complex_mult_arbiter: round-robin from rr_ptr,
// or lowest-index fixed priority when CMA_FIXED_PRIO_EN is defined.
module cma_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_val,
    input  logic [IW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [IW-1:0]      grant_idx,
    output logic               grant_vld
);

    localparam int SW = IW + 1;

    logic [SW-1:0] cand_s;

    // Scan lanes starting at the priority origin; the first valid lane wins
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand_s    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef CMA_FIXED_PRIO_EN
            cand_s = SW'(i);
`else
            cand_s = {1'b0, rr_ptr} + SW'(i);
            if (cand_s >= SW'(NUM_REQ)) begin
                cand_s = cand_s - SW'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
`endif
            if (!grant_vld && req_val[cand_s[IW-1:0]]) begin
                grant_vld                   = 1'b1;
                grant_idx                   = cand_s[IW-1:0];
                grant_oh[cand_s[IW-1:0]]    = 1'b1;
            end else begin
                grant_vld = grant_vld;
            end
        end
    end

endmodule

// File: rtl/complex_mult_arbiter.sv
// Shares one complex multiplier between NUM_REQ requesters, one transaction at a time.
// rst_i is meant to also drive the multiplier's sw_rst_i. Option: CMA_FIXED_PRIO_EN.
module complex_mult_arbiter
    import cma_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DW      = 8,
    localparam int IW     = $clog2(NUM_REQ),
    localparam int LW     = LANE_SLOTS * DW
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_val_i,
    output logic [NUM_REQ-1:0]    req_rdy_o,
    input  logic [NUM_REQ*LW-1:0] req_ops_i,
    output logic [NUM_REQ-1:0]    rsp_val_o,
    input  logic [NUM_REQ-1:0]    rsp_rdy_i,
    output logic [2*DW-1:0]       rsp_re_o,
    output logic [2*DW-1:0]       rsp_im_o,
    output logic                  mul_op_val_o,
    input  logic                  mul_op_rdy_i,
    output logic [DW-1:0]         mul_op_1_re_o,
    output logic [DW-1:0]         mul_op_1_im_o,
    output logic [DW-1:0]         mul_op_2_re_o,
    output logic [DW-1:0]         mul_op_2_im_o,
    input  logic                  mul_res_val_i,
    output logic                  mul_res_rdy_o,
    input  logic [2*DW-1:0]       mul_res_re_i,
    input  logic [2*DW-1:0]       mul_res_im_i,
    output logic                  busy_o,
    output logic [IW-1:0]         grant_id_o
);

    cma_state_e         state_r;
    cma_state_e         state_nxt_s;
    logic [IW-1:0]      rr_ptr_r;
    logic [IW-1:0]      rr_ptr_nxt_s;
    logic [IW-1:0]      grant_id_r;
    logic [NUM_REQ-1:0] grant_oh_s;
    logic [IW-1:0]      grant_idx_s;
    logic               grant_vld_s;
    logic [LW-1:0]      ops_sel_s;
    logic [LW-1:0]      ops_r;
    logic [2*DW-1:0]    res_re_r;
    logic [2*DW-1:0]    res_im_r;
    logic               rsp_take_s;

    cma_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .req_val   (req_val_i),
        .rr_ptr    (rr_ptr_r),
        .grant_oh  (grant_oh_s),
        .grant_idx (grant_idx_s),
        .grant_vld (grant_vld_s)
    );

    // Operand lane mux steered by the one-hot grant
    always_comb begin
        ops_sel_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_oh_s[k]) begin
                ops_sel_s = req_ops_i[k*LW +: LW];
            end else begin
                ops_sel_s = ops_sel_s;
            end
        end
    end

    assign rsp_take_s = rsp_rdy_i[grant_id_r];

`ifdef CMA_FIXED_PRIO_EN
    assign rr_ptr_nxt_s = '0;
`else
    assign rr_ptr_nxt_s = (grant_id_r == IW'(NUM_REQ - 1)) ? '0 : grant_id_r + IW'(1);
`endif

    // Next-state logic for the single-transaction FSM
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_vld_s) state_nxt_s = ISSUE;
                else             state_nxt_s = IDLE;
            end
            ISSUE: begin
                if (mul_op_rdy_i) state_nxt_s = WAIT;
                else              state_nxt_s = ISSUE;
            end
            WAIT: begin
                if (mul_res_val_i) state_nxt_s = DELIVER;
                else               state_nxt_s = WAIT;
            end
            DELIVER: begin
                if (rsp_take_s) state_nxt_s = IDLE;
                else            state_nxt_s = DELIVER;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Transaction datapath: granted operands, grant id, result capture and pointer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_r   <= '0;
            grant_id_r <= '0;
            ops_r      <= '0;
            res_re_r   <= '0;
            res_im_r   <= '0;
        end else begin
            if (state_r == IDLE && grant_vld_s) begin
                ops_r      <= ops_sel_s;
                grant_id_r <= grant_idx_s;
            end
            if (state_r == WAIT && mul_res_val_i) begin
                res_re_r <= mul_res_re_i;
                res_im_r <= mul_res_im_i;
            end
            if (state_r == DELIVER && rsp_take_s) begin
                rr_ptr_r <= rr_ptr_nxt_s;
            end
        end
    end

    // Per-lane handshakes exist only in IDLE (request) and DELIVER (response)
    always_comb begin
        req_rdy_o = '0;
        rsp_val_o = '0;
        if (state_r == IDLE) begin
            req_rdy_o = grant_oh_s;
        end else begin
            req_rdy_o = '0;
        end
        if (state_r == DELIVER) begin
            rsp_val_o[grant_id_r] = 1'b1;
        end else begin
            rsp_val_o = '0;
        end
    end

    assign mul_op_val_o  = (state_r == ISSUE);
    assign mul_res_rdy_o = (state_r == WAIT);
    assign busy_o        = (state_r != IDLE);
    assign grant_id_o    = grant_id_r;
    assign rsp_re_o      = res_re_r;
    assign rsp_im_o      = res_im_r;
    assign mul_op_1_re_o = ops_r[OP1_RE_SLOT*DW +: DW];
    assign mul_op_1_im_o = ops_r[OP1_IM_SLOT*DW +: DW];
    assign mul_op_2_re_o = ops_r[OP2_RE_SLOT*DW +: DW];
    assign mul_op_2_im_o = ops_r[OP2_IM_SLOT*DW +: DW];

endmodule
